// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage in front of a fixed-latency instruction memory.
// Holds the PC, waits MEM_WAIT cycles for the memory word, latches it into the
// instruction register and offers it to decode with a valid/ready handshake.
// Branch/jump redirects override everything and restart the fetch.
// Optional feature: define FETCH_PERF_CNT_EN to build the handshake counter
// behind fetch_count; without it fetch_count is tied to zero.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_instr,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic [31:0] ir_pc_plus4,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    ST_WAIT,
    ST_HOLD
  } state_t;

  localparam logic [3:0] LAST_WAIT = 4'(MEM_WAIT - 1);

  state_t      state;
  logic [31:0] pc;
  logic [3:0]  wait_cnt;
  logic        unused_redirect_lsbs;

  // The two low bits of a redirect target never reach the PC.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // The memory address is the registered PC, so it only moves at clock edges.
  assign mem_addr    = pc;
  assign ir_pc_plus4 = ir_pc + 32'd4;

  // Fetch sequencer: redirect wins, otherwise wait for memory then hold for decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_WAIT;
      pc       <= {RESET_PC[31:2], 2'b00};
      wait_cnt <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[31:2], 2'b00};
      wait_cnt <= '0;
      ir_valid <= 1'b0;
      state    <= ST_WAIT;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            ir       <= mem_instr;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_HOLD;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_HOLD: begin
          if (ir_ready) begin
            pc       <= pc + 32'd4;
            wait_cnt <= '0;
            ir_valid <= 1'b0;
            state    <= ST_WAIT;
          end
        end
        default: begin
          state <= ST_WAIT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Count completed decode handshakes; redirects on the same edge do not cancel them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (ir_valid && ir_ready) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit.
// Expected fetches are queued when stimulus sets the PC flow and popped when
// ir_valid is observed. Honours FETCH_PERF_CNT_EN for fetch_count expectations.
module tb_instr_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_instr;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [31:0] ir_pc_plus4;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  int          nAsserts = 0;
  int          nFails   = 0;
  int          hsCount  = 0;
  logic [31:0] sbq[$];

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .MEM_WAIT(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_addr(mem_addr),
    .mem_instr(mem_instr),
    .ir(ir),
    .ir_pc(ir_pc),
    .ir_pc_plus4(ir_pc_plus4),
    .ir_valid(ir_valid),
    .ir_ready(ir_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .fetch_count(fetch_count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word content of the modelled memory at a byte address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    return (idx * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Memory answers one cycle after the address is presented.
  always @(posedge clk) mem_instr <= memWord(mem_addr);

  function automatic logic [31:0] expFc(input int n);
    return PERF ? 32'(n) : 32'h0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic ready, input logic rdv, input logic [31:0] rdpc);
    ir_ready       = ready;
    redirect_valid = rdv;
    redirect_pc    = rdpc;
  endtask

  task automatic checkHead(input string tag);
    logic [31:0] pcExp;
    if (sbq.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'(sbq.size()), 32'd1);
    end else begin
      pcExp = sbq.pop_front();
      checkOutput({tag, "_ir_pc"}, ir_pc, pcExp);
      checkOutput({tag, "_ir"}, ir, memWord(pcExp));
      checkOutput({tag, "_ir_pc_plus4"}, ir_pc_plus4, pcExp + 32'd4);
    end
  endtask

  // Starting just after the edge that set the address: two edges to a valid IR.
  task automatic expectFetch(input string tag);
    cycle();
    checkOutput({tag, "_valid_early"}, {31'b0, ir_valid}, 32'd0);
    cycle();
    checkOutput({tag, "_valid"}, {31'b0, ir_valid}, 32'd1);
    checkHead(tag);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
    checkOutput({tag, "_ir"}, ir, 32'h0);
    checkOutput({tag, "_ir_pc"}, ir_pc, 32'h0);
    checkOutput({tag, "_ir_pc_plus4"}, ir_pc_plus4, 32'h4);
    checkOutput({tag, "_ir_valid"}, {31'b0, ir_valid}, 32'd0);
    checkOutput({tag, "_fetch_count"}, fetch_count, 32'h0);
  endtask

  // Directed sequence covering reset, streaming, stalls, redirects and wrap.
  initial begin
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0);
    #1 rst_n = 1'b0;
    #2 checkReset("reset0");
    repeat (3) cycle();
    rst_n = 1'b1;

    // Stream from reset with decode always ready.
    sbq.push_back(32'h0);
    expectFetch("first");
    for (int k = 1; k <= 3; k++) begin
      sbq.push_back(32'(4 * k));
      cycle();
      hsCount++;
      checkOutput("stream_addr", mem_addr, 32'(4 * k));
      checkOutput("stream_valid_drop", {31'b0, ir_valid}, 32'd0);
      expectFetch("stream");
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("fc_after_stream", fetch_count, expFc(hsCount));

    // Decode stalls for ten cycles: everything holds.
    for (int k = 0; k < 10; k++) begin
      cycle();
      checkOutput("stall_valid", {31'b0, ir_valid}, 32'd1);
      checkOutput("stall_ir_pc", ir_pc, 32'hC);
      checkOutput("stall_ir", ir, memWord(32'hC));
      checkOutput("stall_addr", mem_addr, 32'hC);
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    sbq.push_back(32'h10);
    cycle();
    hsCount++;
    checkOutput("release_addr", mem_addr, 32'h10);
    checkOutput("release_valid", {31'b0, ir_valid}, 32'd0);

    // Redirect during WAIT to an unaligned target.
    applyStimulus(1'b1, 1'b1, 32'h1F);
    sbq.delete();
    sbq.push_back(32'h1C);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir_addr", mem_addr, 32'h1C);
    checkOutput("redir_valid", {31'b0, ir_valid}, 32'd0);
    expectFetch("redir");

    // Move to PC 8 without a handshake, then redirect on a handshake edge.
    applyStimulus(1'b0, 1'b1, 32'h8);
    sbq.push_back(32'h8);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("to8_addr", mem_addr, 32'h8);
    expectFetch("at8");
    applyStimulus(1'b1, 1'b1, 32'h40);
    sbq.push_back(32'h40);
    cycle();
    hsCount++;
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("rhs_addr", mem_addr, 32'h40);
    checkOutput("rhs_valid", {31'b0, ir_valid}, 32'd0);
    checkOutput("rhs_fc", fetch_count, expFc(hsCount));
    expectFetch("rhs");

    // Redirect to the last word, then accept and wrap to zero.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    sbq.push_back(32'hFFFF_FFFC);
    cycle();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("top_addr", mem_addr, 32'hFFFF_FFFC);
    expectFetch("top");
    applyStimulus(1'b1, 1'b0, 32'h0);
    sbq.push_back(32'h0);
    cycle();
    hsCount++;
    checkOutput("wrap_addr", mem_addr, 32'h0);
    checkOutput("wrap_fc", fetch_count, expFc(hsCount));
    expectFetch("wrap");

    // Reset while holding a valid word at a non-reset PC.
    applyStimulus(1'b0, 1'b1, 32'h100);
    sbq.push_back(32'h100);
    cycle();
    applyStimulus(1'b0, 1'b0, 32'h0);
    expectFetch("pre_hold_reset");
    #2 rst_n = 1'b0;
    #1 checkReset("reset_hold");
    cycle();
    hsCount = 0;
    sbq.delete();
    rst_n = 1'b1;

    // Reset while waiting on memory at a non-reset PC.
    applyStimulus(1'b1, 1'b1, 32'h200);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("mid_wait_addr", mem_addr, 32'h200);
    cycle();
    checkOutput("mid_wait_valid", {31'b0, ir_valid}, 32'd0);
    #2 rst_n = 1'b0;
    #1 checkReset("reset_wait");
    cycle();
    rst_n = 1'b1;
    sbq.push_back(32'h0);
    expectFetch("restart");
    checkOutput("restart_fc", fetch_count, expFc(hsCount));

    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
